// File: rtl/uart_alu_interface.sv
// Byte-level command decoder sitting between the UART receiver/transmitter
// and a combinational ALU. Bytes arrive as (type, value) pairs; an opcode
// write captures the ALU result and hands it to the transmitter.
module uart_alu_interface #(
  parameter int unsigned          NB_DATA = 8,
  parameter int unsigned          NB_OP   = 6,
  parameter logic [NB_DATA-1:0]   TYPE_A  = 8'h08,
  parameter logic [NB_DATA-1:0]   TYPE_B  = 8'h10,
  parameter logic [NB_DATA-1:0]   TYPE_OP = 8'h20
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_VAL = 2'd1,
    EXEC    = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_A  = 2'd0,
    SEL_B  = 2'd1,
    SEL_OP = 2'd2
  } sel_t;

  state_t state_q;
  state_t state_d;
  sel_t   sel_q;
  sel_t   sel_c;
  logic   rx_is_type_c;
  logic   type_accept_c;
  logic   val_accept_c;

  // Classify the incoming byte as one of the known type codes
  always_comb begin
    rx_is_type_c = 1'b1;
    sel_c        = SEL_A;
    if (i_rx_data == TYPE_A) begin
      sel_c = SEL_A;
    end else if (i_rx_data == TYPE_B) begin
      sel_c = SEL_B;
    end else if (i_rx_data == TYPE_OP) begin
      sel_c = SEL_OP;
    end else begin
      rx_is_type_c = 1'b0;
    end
  end

  assign type_accept_c = (state_q == IDLE) && i_rx_done && rx_is_type_c;
  assign val_accept_c  = (state_q == GET_VAL) && i_rx_done;

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; bytes in EXEC/WAIT_TX are ignored, tx_done wins in WAIT_TX
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (type_accept_c) state_d = GET_VAL;
      GET_VAL: if (i_rx_done) state_d = (sel_q == SEL_OP) ? EXEC : IDLE;
      EXEC:    state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Selector, operand/opcode registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      sel_q      <= SEL_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_err      <= (state_q == IDLE) && i_rx_done && !rx_is_type_c;
      o_tx_start <= (state_q == EXEC);
      o_busy     <= (state_d == EXEC) || (state_d == WAIT_TX);
      if (type_accept_c) begin
        sel_q <= sel_c;
      end
      if (val_accept_c) begin
        unique case (sel_q)
          SEL_A:   o_data_a <= i_rx_data;
          SEL_B:   o_data_b <= i_rx_data;
          SEL_OP:  o_op     <= i_rx_data[NB_OP-1:0];
          default: ;
        endcase
      end
      if (state_q == EXEC) begin
        o_tx_data <= i_alu_result;
      end
    end
  end

endmodule
